vga_timing_gen: RTL and testbench

- Generates the VGA 640x480@60 raster: pixel-enable tick, h_cnt/v_cnt scan counters, active-video flag, and active-low sync pulses.
- Drives the h_cnt/v_cnt inputs of the display address path (sprite/interface/map selection) and the RGB output stage.
- Also provides sync/valid copies delayed by a fixed number of pixel ticks, aligning them with pixel data returned from block-ROM after the address path.

---
 rtl/vga_timing_gen_pkg.sv | 42 ++++
 rtl/vga_timing_gen_sync_delay_line.sv | 43 ++++
 rtl/vga_timing_gen.sv | 145 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared constants and encodings for the display pipeline.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Holds the nominal 640x480@60 timing values used as defaults by
// vga_timing_gen, the derived line/frame totals, and the game state
// encodings shared by the display blocks (address path, RGB stage).
package vga_timing_gen_pkg;

   // 640x480@60 timing, in pixels (horizontal) and lines (vertical)
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;  // 800
   localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;  // 525

   // Game state encodings seen by the display blocks
   localparam logic [3:0] TITLE     = 4'd0;
   localparam logic [3:0] MENU      = 4'd1;
   localparam logic [3:0] PLAY      = 4'd2;
   localparam logic [3:0] PAUSE     = 4'd3;
   localparam logic [3:0] LEVEL_UP  = 4'd4;
   localparam logic [3:0] DYING     = 4'd5;
   localparam logic [3:0] GAME_OVER = 4'd6;
   localparam logic [3:0] WIN       = 4'd7;
   localparam logic [3:0] SCORES    = 4'd8;
   localparam logic [3:0] HELP      = 4'd9;

   // True when lo <= cnt < hi
   function automatic logic in_window(input logic [9:0] cnt,
                                      input logic [9:0] lo,
                                      input logic [9:0] hi);
      return (cnt >= lo) && (cnt < hi);
   endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// N-stage single-bit shift register with enable and configurable reset value.
// Latency: N enabled cycles (N=0 is a plain wire).
// Backpressure: none; shifts whenever en is high.
//
// Ports: clk, rst (sync, active high), en (shift strobe), din, dout.
module sync_delay_line
   import vga_timing_gen_pkg::*;
#(
   parameter int   N       = 2,
   parameter logic RST_VAL = 1'b0
)(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic din,
   output logic dout
);

   generate
      if (N == 0) begin : g_wire
         assign dout = din;
         // clock/reset/enable have no role without storage
         logic unused_ok;
         assign unused_ok = ^{clk, rst, en};
      end else begin : g_sr
         logic [N-1:0] sr;

         always_ff @(posedge clk) begin
            if (rst) begin
               sr <= {N{RST_VAL}};
            end else if (en) begin
               sr[0] <= din;
               for (int i = 1; i < N; i++) begin
                  sr[i] <= sr[i-1];
               end
            end
         end

         assign dout = sr[N-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel tick, scan counters, active flag, active-low syncs.
// Latency: decodes are zero-latency from counters; *_d outputs lag SYNC_DELAY pixel ticks.
// Backpressure: none; free-running raster.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   pclk_en           one-clk pulse per pixel (every CLK_DIV clks)
//   h_cnt, v_cnt      scan position
//   valid/hsync/vsync decodes of h_cnt/v_cnt (syncs active low)
//   *_d               same, delayed to line up with block-ROM pixel data
//   line_start        one clk on each horizontal wrap
//   frame_start       one clk on each frame wrap
//   frame_cnt         frame counter, only when VGA_FRAME_CNT_EN is defined
module vga_timing_gen
   import vga_timing_gen_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int H_ACTIVE   = VGA_H_ACTIVE,
   parameter int H_FP       = VGA_H_FP,
   parameter int H_SYNC     = VGA_H_SYNC,
   parameter int H_BP       = VGA_H_BP,
   parameter int V_ACTIVE   = VGA_V_ACTIVE,
   parameter int V_FP       = VGA_V_FP,
   parameter int V_SYNC     = VGA_V_SYNC,
   parameter int V_BP       = VGA_V_BP,
   parameter int SYNC_DELAY = 2
)(
   input  logic       clk,
   input  logic       rst,
   output logic       pclk_en,
   output logic [9:0] h_cnt,
   output logic [9:0] v_cnt,
   output logic       valid,
   output logic       hsync,
   output logic       vsync,
   output logic       valid_d,
   output logic       hsync_d,
   output logic       vsync_d,
   output logic       line_start,
   output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [7:0] frame_cnt
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   // Simulation-only guard: totals must fit the 10-bit counters
   always @(posedge clk) begin : param_chk
      assert (H_TOTAL <= 1024 && V_TOTAL <= 1024)
         else $error("vga_timing_gen: H_TOTAL=%0d V_TOTAL=%0d exceed 1024", H_TOTAL, V_TOTAL);
   end

   // ---------------- pixel clock divider ----------------
   logic [3:0] div;

   // pclk_en is the registered decode of the last divider phase, so it is
   // high while div is back at 0; with CLK_DIV=1 it stays high after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         div     <= '0;
         pclk_en <= 1'b0;
      end else begin
         pclk_en <= (div == DIV_LAST);
         div     <= (div == DIV_LAST) ? 4'd0 : div + 4'd1;
      end
   end

   // ---------------- scan counters ----------------
   logic h_wrap, v_wrap;
   assign h_wrap = (h_cnt == H_LAST);
   assign v_wrap = (v_cnt == V_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         // Pulses land in the clk where the wrapped counter value is visible
         line_start  <= pclk_en && h_wrap;
         frame_start <= pclk_en && h_wrap && v_wrap;
         if (pclk_en) begin
            h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
            if (h_wrap) begin
               v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
            end
         end
      end
   end

`ifdef VGA_FRAME_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt <= '0;
      end else if (pclk_en && h_wrap && v_wrap) begin
         frame_cnt <= frame_cnt + 8'd1;
      end
   end
`endif

   // ---------------- decodes ----------------
   assign valid = (h_cnt < H_VIS) && (v_cnt < V_VIS);
   assign hsync = ~in_window(h_cnt, HS_BEG, HS_END);
   assign vsync = ~in_window(v_cnt, VS_BEG, VS_END);

   // ---------------- delayed copies for ROM-aligned pixel data ----------------
   sync_delay_line #(.N(SYNC_DELAY), .RST_VAL(1'b0)) u_valid_dl (
      .clk  (clk),
      .rst  (rst),
      .en   (pclk_en),
      .din  (valid),
      .dout (valid_d)
   );

   sync_delay_line #(.N(SYNC_DELAY), .RST_VAL(1'b1)) u_hsync_dl (
      .clk  (clk),
      .rst  (rst),
      .en   (pclk_en),
      .din  (hsync),
      .dout (hsync_d)
   );

   sync_delay_line #(.N(SYNC_DELAY), .RST_VAL(1'b1)) u_vsync_dl (
      .clk  (clk),
      .rst  (rst),
      .en   (pclk_en),
      .din  (vsync),
      .dout (vsync_d)
   );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen using a reduced raster so whole frames fit in a short run.
// Instance A: CLK_DIV=4, SYNC_DELAY=2. Instance B: CLK_DIV=1, SYNC_DELAY=0.
// Outputs are compared every clk against a position-arithmetic model.
module tb_vga_timing_gen;

   localparam int HA = 10, HFP = 2, HS = 3, HBP = 2;
   localparam int VA = 6,  VFP = 1, VS = 2, VBP = 1;
   localparam int HT = HA + HFP + HS + HBP;   // 17
   localparam int VT = VA + VFP + VS + VBP;   // 10
   localparam int FT = HT * VT;               // 170 pixel ticks per frame

   typedef struct packed {
      logic       pclk_en;
      logic [9:0] h;
      logic [9:0] v;
      logic       valid;
      logic       hs;
      logic       vs;
      logic       valid_d;
      logic       hs_d;
      logic       vs_d;
      logic       ls;
      logic       fs;
      logic [7:0] fc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       a_pclk, a_valid, a_hs, a_vs, a_vd, a_hsd, a_vsd, a_ls, a_fs;
   logic       b_pclk, b_valid, b_hs, b_vs, b_vd, b_hsd, b_vsd, b_ls, b_fs;
   logic [9:0] a_h, a_v, b_h, b_v;
   logic [7:0] a_fc, b_fc;
`ifndef VGA_FRAME_CNT_EN
   assign a_fc = '0;
   assign b_fc = '0;
`endif

   vga_timing_gen #(
      .CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_DELAY(2)
   ) dut_a (
      .clk(clk), .rst(rst), .pclk_en(a_pclk), .h_cnt(a_h), .v_cnt(a_v),
      .valid(a_valid), .hsync(a_hs), .vsync(a_vs),
      .valid_d(a_vd), .hsync_d(a_hsd), .vsync_d(a_vsd),
      .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_FRAME_CNT_EN
      , .frame_cnt(a_fc)
`endif
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_DELAY(0)
   ) dut_b (
      .clk(clk), .rst(rst), .pclk_en(b_pclk), .h_cnt(b_h), .v_cnt(b_v),
      .valid(b_valid), .hsync(b_hs), .vsync(b_vs),
      .valid_d(b_vd), .hsync_d(b_hsd), .vsync_d(b_vsd),
      .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_FRAME_CNT_EN
      , .frame_cnt(b_fc)
`endif
   );

   exp_t act_a, act_b;
   assign act_a = {a_pclk, a_h, a_v, a_valid, a_hs, a_vs, a_vd, a_hsd, a_vsd, a_ls, a_fs, a_fc};
   assign act_b = {b_pclk, b_h, b_v, b_valid, b_hs, b_vs, b_vd, b_hsd, b_vsd, b_ls, b_fs, b_fc};

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   task automatic chk_int(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_vec(input string nm, input exp_t act, input exp_t exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails <= 20)
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
      end
   endtask

   // A wait that ran out of budget is reported as a failed comparison
   task automatic tmo(input string nm, input int n, input int lim);
      chk_int({nm, "_in_time"}, (n < lim) ? 1 : 0, 1);
   endtask

   // ---------------- reference model ----------------
   // Position since reset = number of pixel ticks taken; all outputs follow
   // from that count and the raster geometry.
   function automatic logic vld_of(input int p);
      return ((p % HT) < HA) && ((p / HT) < VA);
   endfunction
   function automatic logic hs_of(input int p);
      return !(((p % HT) >= HA + HFP) && ((p % HT) < HA + HFP + HS));
   endfunction
   function automatic logic vs_of(input int p);
      return !(((p / HT) >= VA + VFP) && ((p / HT) < VA + VFP + VS));
   endfunction

   function automatic exp_t model(input int c, input int t, input bit adv,
                                  input int cdiv, input int dly);
      exp_t e;
      int   pos, p2;
      pos       = t % FT;
      e.pclk_en = (c > 0) && (c % cdiv == 0);
      e.h       = 10'(pos % HT);
      e.v       = 10'(pos / HT);
      e.valid   = vld_of(pos);
      e.hs      = hs_of(pos);
      e.vs      = vs_of(pos);
      if (t >= dly) begin
         p2        = (t - dly) % FT;
         e.valid_d = vld_of(p2);
         e.hs_d    = hs_of(p2);
         e.vs_d    = vs_of(p2);
      end else begin
         e.valid_d = 1'b0;
         e.hs_d    = 1'b1;
         e.vs_d    = 1'b1;
      end
      e.ls = adv && (pos % HT == 0);
      e.fs = adv && (pos == 0);
`ifdef VGA_FRAME_CNT_EN
      e.fc = 8'((t / FT) % 256);
`else
      e.fc = '0;
`endif
      return e;
   endfunction

   // c = clks since reset, t = pixel ticks taken, adv = tick taken at last edge
   int ca = 0, ta = 0, cb = 0, tb = 0;
   bit adva = 1'b0, advb = 1'b0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         ca <= 0; ta <= 0; adva <= 1'b0;
         cb <= 0; tb <= 0; advb <= 1'b0;
      end else begin
         adva <= (ca > 0) && (ca % 4 == 0);
         ta   <= ta + (((ca > 0) && (ca % 4 == 0)) ? 1 : 0);
         ca   <= ca + 1;
         advb <= (cb > 0);
         tb   <= tb + ((cb > 0) ? 1 : 0);
         cb   <= cb + 1;
      end
   end

   bit chk_en = 1'b0;
   always @(negedge clk) begin
      if (chk_en) begin
         chk_vec("dut_a_cycle", act_a, model(ca, ta, adva, 4, 2));
         chk_vec("dut_b_cycle", act_b, model(cb, tb, advb, 1, 0));
      end
   end

   // ---------------- directed sequence with literal expectations ----------------
   initial begin
      int n, t0;
      repeat (5) @(negedge clk);
      chk_en = 1'b1;
      rst    = 1'b0;

      // reset state before the first released edge
      chk_int("rst_h_cnt",   a_h,   0);
      chk_int("rst_v_cnt",   a_v,   0);
      chk_int("rst_hsync",   a_hs,  1);
      chk_int("rst_vsync",   a_vs,  1);
      chk_int("rst_hsync_d", a_hsd, 1);
      chk_int("rst_vsync_d", a_vsd, 1);
      chk_int("rst_valid_d", a_vd,  0);
      chk_int("rst_fs",      a_fs,  0);

      // first pclk_en on the 4th clk after release, then period 4
      n = 0;
      do begin @(negedge clk); n++; end while (!a_pclk && n < 20);
      chk_int("first_pclk_en_clk", n, 4);
      n = 0;
      do begin @(negedge clk); n++; end while (!a_pclk && n < 20);
      chk_int("pclk_en_period", n, 4);

      // hsync falls at h=12, hsync_d 8 clks later, hsync low 12 clks
      n = 0;
      while (a_hs && n < 200) begin @(negedge clk); n++; end
      tmo("hsync_fall", n, 200);
      chk_int("hsync_fall_h", a_h, 12);
      t0 = cyc;
      n = 0;
      while (a_hsd && n < 200) begin @(negedge clk); n++; end
      tmo("hsync_d_fall", n, 200);
      chk_int("hsync_d_lag_clks", cyc - t0, 8);
      n = 0;
      while (!a_hs && n < 200) begin @(negedge clk); n++; end
      tmo("hsync_rise", n, 200);
      chk_int("hsync_low_clks", cyc - t0, 12);

      // h wrap: line_start with h=0 and v stepped to 1; valid drops at h=10
      n = 0;
      while (!a_ls && n < 200) begin @(negedge clk); n++; end
      tmo("line_start", n, 200);
      chk_int("ls_h_cnt", a_h, 0);
      chk_int("ls_v_cnt", a_v, 1);
      n = 0;
      while (a_valid && n < 200) begin @(negedge clk); n++; end
      tmo("valid_fall", n, 200);
      chk_int("valid_fall_h", a_h, 10);

      // vsync low for v=7..8 only: 2 lines * 17 px * 4 clks
      n = 0;
      while (a_vs && n < 2000) begin @(negedge clk); n++; end
      tmo("vsync_fall", n, 2000);
      chk_int("vsync_fall_v", a_v, 7);
      t0 = cyc;
      n = 0;
      while (!a_vs && n < 2000) begin @(negedge clk); n++; end
      tmo("vsync_rise", n, 2000);
      chk_int("vsync_low_clks", cyc - t0, 136);

      // frame_start period: 170 ticks = 680 clks on A
      n = 0;
      while (!a_fs && n < 2000) begin @(negedge clk); n++; end
      tmo("fs_a_1", n, 2000);
      chk_int("fs_ls_coincident", a_ls, 1);
      t0 = cyc;
      @(negedge clk);
      n = 0;
      while (!a_fs && n < 2000) begin @(negedge clk); n++; end
      tmo("fs_a_2", n, 2000);
      chk_int("fs_a_period_clks", cyc - t0, 680);

      // CLK_DIV=1: pclk_en constant, frame every 170 clks
      chk_int("b_pclk_en_high", b_pclk, 1);
      n = 0;
      while (!b_fs && n < 500) begin @(negedge clk); n++; end
      tmo("fs_b_1", n, 500);
      t0 = cyc;
      @(negedge clk);
      n = 0;
      while (!b_fs && n < 500) begin @(negedge clk); n++; end
      tmo("fs_b_2", n, 500);
      chk_int("fs_b_period_clks", cyc - t0, 170);

      // mid-frame reset at h=5, v=3
      n = 0;
      while (!(a_h == 10'd5 && a_v == 10'd3) && n < 2000) begin @(negedge clk); n++; end
      tmo("mid_frame_pos", n, 2000);
      rst = 1'b1;
      @(negedge clk);
      chk_int("mid_rst_h",       a_h,    0);
      chk_int("mid_rst_v",       a_v,    0);
      chk_int("mid_rst_pclk_en", a_pclk, 0);
      chk_int("mid_rst_valid_d", a_vd,   0);
      chk_int("mid_rst_hsync_d", a_hsd,  1);
      rst = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!a_pclk && n < 20);
      chk_int("mid_rst_first_pclk_clk", n, 4);

`ifdef VGA_FRAME_CNT_EN
      // 256 frames on B: counter steps 1..255 then wraps to 0
      begin
         int k;
         k = 0;
         n = 0;
         while (k < 256 && n < 256 * FT + 500) begin
            @(negedge clk);
            n++;
            if (b_fs) begin
               k++;
               if (k == 1) chk_int("frame_cnt_first", b_fc, 1);
            end
         end
         tmo("frame_cnt_256", n, 256 * FT + 500);
         chk_int("frame_cnt_wrap", b_fc, 0);
      end
`else
      repeat (2000) @(negedge clk);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
